pool_stream: RTL and testbench
==============================

# pool_stream

Streaming 2-D pooling engine for the feature-map pipeline. It replaces the fixed-window, max-only pooling path, taking a raster pixel stream with all channels in parallel and keeping its own line buffers. Window size, stride and mode (max/average) are set at run time and latched per frame. Only fully covered windows are pooled, so no padding is applied. It sits between a convolution output stream and the next layer's input.

## Interface
- FRAME_H_MAX, 224, max frame height
- FRAME_W_MAX, 224, max frame width (line-buffer depth)
- WIN_MAX, 3, max window edge
- STRIDE_MAX, 4, max stride
- DATA_WIDTH, 8, unsigned sample width
- CH_NUM, 16, channels processed in parallel
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- frame_h  in  clog2(FRAME_H_MAX)+1  frame height
- frame_w  in  clog2(FRAME_W_MAX)+1  frame width
- win_size  in  clog2(WIN_MAX)+1  window edge k
- stride  in  clog2(STRIDE_MAX)+1  stride s
- mode  in  1  0 = max, 1 = average
- fin_start  in  1  first pixel of frame, qualified by din_vld
- din_vld  in  1  input beat valid
- din  in  CH_NUM×DATA_WIDTH  pixel, all channels
- fout_start  out  1  marks first output beat of frame
- dout_vld  out  1  output beat valid
- dout  out  CH_NUM×DATA_WIDTH  pooled pixel
- cfg_err  out  1  current frame rejected

## Operation
- Config latch: frame_h, frame_w, win_size, stride and mode are sampled on the beat with fin_start & din_vld. They are ignored at all other times.
- States:
  - IDLE: waits for fin_start & din_vld.
  - RUN: frame accepted.
  - DROP: frame rejected.
- Transitions:
  - fin_start & din_vld with a legal config → RUN.
  - fin_start & din_vld with an illegal config → DROP.
  - Last pixel (h-1, w-1) accepted → IDLE.
  - fin_start & din_vld in RUN or DROP aborts the current frame and restarts from pixel (0,0) with the new config. The window and line buffer from the aborted frame are discarded; no output of the old frame is emitted after the abort beat.
- Legal config: 1 ≤ k ≤ WIN_MAX, 1 ≤ s ≤ STRIDE_MAX, k ≤ h ≤ FRAME_H_MAX, k ≤ w ≤ FRAME_W_MAX.
- DROP behaviour: cfg_err = 1 and no dout_vld. cfg_err clears on the next legal fin_start beat.
- Counters: row/column counters advance only on din_vld. The column wraps at w-1 and increments the row.
- Line buffer: WIN_MAX-1 rows, FRAME_W_MAX deep, CH_NUM×DATA_WIDTH wide.
- Window register: WIN_MAX×WIN_MAX. Only the top-left k×k region is used; unused taps are masked (max: 0, avg: excluded).
- Emit rule: the input pixel (r, c) completes a window iff all of the following hold:
  - r ≥ k-1 and c ≥ k-1
  - (r-k+1) mod s = 0 and (c-k+1) mod s = 0
- Output frame size: floor((h-k)/s)+1 by floor((w-k)/s)+1.
- Max mode: per-channel unsigned maximum of the k² samples.
- Average mode: per-channel floor(sum/k²).
  - Sum width: DATA_WIDTH + clog2(WIN_MAX²).
  - Division is a reciprocal multiply and must be exact for all sums ≤ k²·(2^DATA_WIDTH − 1).
- No backpressure. Gaps in din_vld are allowed anywhere.

## Timing
- Reset values: fout_start = 0, dout_vld = 0, dout = 0, cfg_err = 0, state IDLE, all counters 0.
- Latency: dout_vld rises exactly 2 cycles after the din_vld beat that completes a window (stage 1: reduce/sum, stage 2: max-select or divide, registered).
- fout_start is high on the same cycle as the first dout_vld of a frame and is never high without dout_vld.
- dout holds its last value when dout_vld = 0.
- Throughput: one output beat per cycle at most. Pipeline stages advance every cycle independent of din_vld.
- Abort on the same cycle as pipeline flush: beats already inside the 2-stage pipeline still emerge; later beats follow the new frame.
- Asserting reset mid-frame clears the pipeline immediately; outputs take their reset values asynchronously.

## Configuration
- POOL_AVG_EN defined: average datapath (adder tree, reciprocal multiplier) is built and mode is honoured.
- POOL_AVG_EN undefined: no average datapath is built, mode is ignored and max is always used. A frame with mode = 1 is still processed as max, with no error.

## Test plan
- 4×4 frame, k=2, s=2, max, ch0 = 0..15 raster → 4 outputs 5, 7, 13, 15. fout_start on the first; each appears 2 cycles after the inputs at (1,1), (1,3), (3,1), (3,3).
- 5×5 frame, k=3, s=1, avg, all samples 255 → 9 outputs of 255 (exact divide). The same run with ch1 = 1 at every pixel → ch1 outputs 1.
- 4×4 frame, k=2, s=2, max, din_vld toggled 1/0 each cycle → same 4 values; each lags its completing beat by exactly 2 cycles.
- k=4 on a 3×3 frame → cfg_err = 1, no dout_vld. A following legal 4×4 frame with k=2, s=2 → cfg_err cleared and 4 outputs.
- New fin_start at pixel (2,1) of a 4×4 frame → no old-frame output after the abort beat; the new frame produces its full 4 outputs.
- Assert reset during an emitting cycle → dout_vld, fout_start and dout read 0 before the next clock edge. Next frame is correct.

Source files
------------

// File: rtl/pool_stream_if.sv
// pool_stream_if: pixel stream with per-frame config in, pooled pixel stream and error flag out
interface pool_stream_if #(
    parameter int FRAME_H_MAX = 224,
    parameter int FRAME_W_MAX = 224,
    parameter int WIN_MAX     = 3,
    parameter int STRIDE_MAX  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int CH_NUM      = 16
);
    logic [$clog2(FRAME_H_MAX):0]   frame_h;
    logic [$clog2(FRAME_W_MAX):0]   frame_w;
    logic [$clog2(WIN_MAX):0]       win_size;
    logic [$clog2(STRIDE_MAX):0]    stride;
    logic                           mode;
    logic                           fin_start;
    logic                           din_vld;
    logic [CH_NUM*DATA_WIDTH-1:0]   din;
    logic                           fout_start;
    logic                           dout_vld;
    logic [CH_NUM*DATA_WIDTH-1:0]   dout;
    logic                           cfg_err;

    modport master (
        output frame_h, frame_w, win_size, stride, mode, fin_start, din_vld, din,
        input  fout_start, dout_vld, dout, cfg_err
    );
    modport slave (
        input  frame_h, frame_w, win_size, stride, mode, fin_start, din_vld, din,
        output fout_start, dout_vld, dout, cfg_err
    );
endinterface

// File: rtl/pool_stream.sv
// pool_stream: streaming k x k max/average pooling with own line buffers; POOL_AVG_EN builds the average path
module pool_stream #(
    parameter int FRAME_H_MAX = 224,
    parameter int FRAME_W_MAX = 224,
    parameter int WIN_MAX     = 3,
    parameter int STRIDE_MAX  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int CH_NUM      = 16
) (
    input logic clk_i,
    input logic rst_i,
    pool_stream_if.slave bus
);
    localparam int HW = $clog2(FRAME_H_MAX) + 1;
    localparam int WW = $clog2(FRAME_W_MAX) + 1;
    localparam int KW = $clog2(WIN_MAX) + 1;
    localparam int SW = $clog2(STRIDE_MAX) + 1;
    typedef logic [CH_NUM-1:0][DATA_WIDTH-1:0] pix_t;
    typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

    state_t state_q;
    logic [HW-1:0] h_q, h_c, r_q, r_c, r_d;
    logic [WW-1:0] w_q, w_c, c_q, c_c, c_d;
    logic [KW-1:0] k_q, k_c;
    logic [SW-1:0] s_q, s_c, rph_q, rph_c, rph_d, cph_q, cph_c, cph_d;
    logic start, legal, run_c, beat, emit, last_col, last_pix, first_q, first_d, err_q;
    logic v1_q, f1_q, vld_q, fout_q;
    pix_t lb_q [WIN_MAX-1][FRAME_W_MAX];
    pix_t win_q [WIN_MAX][WIN_MAX];
    pix_t win_d [WIN_MAX][WIN_MAX];
    pix_t col [WIN_MAX];
    pix_t mx0, mx1_q, res, dout_q;
    logic [WW-2:0] ci;

    // The fin_start beat is pixel (0,0) of the new frame, so it sees its own config and zeroed counters
    assign start = bus.din_vld & bus.fin_start;
    assign legal = bus.win_size != '0 && bus.win_size <= KW'(WIN_MAX) &&
                   bus.stride != '0 && bus.stride <= SW'(STRIDE_MAX) &&
                   bus.frame_h >= HW'(bus.win_size) && bus.frame_h <= HW'(FRAME_H_MAX) &&
                   bus.frame_w >= WW'(bus.win_size) && bus.frame_w <= WW'(FRAME_W_MAX);
    assign h_c = start ? bus.frame_h : h_q;
    assign w_c = start ? bus.frame_w : w_q;
    assign k_c = start ? bus.win_size : k_q;
    assign s_c = start ? bus.stride : s_q;
    assign r_c = start ? '0 : r_q;
    assign c_c = start ? '0 : c_q;
    assign rph_c = start ? '0 : rph_q;
    assign cph_c = start ? '0 : cph_q;
    assign run_c = start ? legal : state_q == RUN;
    assign beat = bus.din_vld & (start | state_q != IDLE);
    assign last_col = c_c == w_c - WW'(1);
    assign last_pix = last_col & (r_c == h_c - HW'(1));
    assign emit = beat & run_c & (r_c >= HW'(k_c) - HW'(1)) & (c_c >= WW'(k_c) - WW'(1)) &
                  (rph_c == '0) & (cph_c == '0);
    assign c_d = (last_col || last_pix) ? '0 : c_c + WW'(1);
    assign r_d = last_pix ? '0 : last_col ? r_c + HW'(1) : r_c;
    assign cph_d = (last_col || c_c < WW'(k_c) - WW'(1) || cph_c == s_c - SW'(1)) ? '0 : cph_c + SW'(1);
    assign rph_d = !last_col ? rph_c :
                   (last_pix || r_c < HW'(k_c) - HW'(1) || rph_c == s_c - SW'(1)) ? '0 : rph_c + SW'(1);
    assign first_d = (start | first_q) & ~emit;
    assign ci = c_c[WW-2:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            {h_q, w_q, k_q, s_q} <= '0;
            {r_q, c_q, rph_q, cph_q} <= '0;
            first_q <= 1'b0;
            err_q <= 1'b0;
        end else if (beat) begin
            state_q <= last_pix ? IDLE : start ? (legal ? RUN : DROP) : state_q;
            r_q <= r_d;
            c_q <= c_d;
            rph_q <= rph_d;
            cph_q <= cph_d;
            first_q <= first_d;
            if (start) begin
                {h_q, w_q, k_q, s_q} <= {bus.frame_h, bus.frame_w, bus.win_size, bus.stride};
                err_q <= ~legal;
            end
        end
    end

    // Column vector is rows r, r-1, ... ; window column 0 is the newest column
    always_comb begin
        col[0] = bus.din;
        for (int i = 1; i < WIN_MAX; i++) col[i] = lb_q[i-1][ci];
        for (int i = 0; i < WIN_MAX; i++)
            for (int j = 0; j < WIN_MAX; j++) win_d[i][j] = j == 0 ? col[i] : win_q[i][j-1];
    end

    always_ff @(posedge clk_i) begin
        if (beat && run_c) begin
            win_q <= win_d;
            lb_q[0][ci] <= bus.din;
            for (int i = 1; i < WIN_MAX - 1; i++) lb_q[i][ci] <= lb_q[i-1][ci];
        end
    end

    always_comb begin
        mx0 = '0;
        for (int ch = 0; ch < CH_NUM; ch++)
            for (int i = 0; i < WIN_MAX; i++)
                for (int j = 0; j < WIN_MAX; j++)
                    if (KW'(i) < k_c && KW'(j) < k_c && win_d[i][j][ch] > mx0[ch]) mx0[ch] = win_d[i][j][ch];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            {v1_q, f1_q, vld_q, fout_q} <= '0;
            mx1_q <= '0;
            dout_q <= '0;
        end else begin
            v1_q <= emit;
            f1_q <= emit & (start | first_q);
            if (emit) mx1_q <= mx0;
            vld_q <= v1_q;
            fout_q <= f1_q;
            if (v1_q) dout_q <= res;
        end
    end

`ifdef POOL_AVG_EN
    localparam int CW = $clog2(WIN_MAX * WIN_MAX);
    localparam int AW = DATA_WIDTH + CW;
    localparam int SH = DATA_WIDTH + 2 * CW;
    localparam int RW = SH + 1;
    logic [CH_NUM-1:0][AW-1:0] sm0, sm1_q;
    logic [RW-1:0] rcp_tab [2**KW];
    logic [RW-1:0] rcp1_q;
    logic mode_q, avg1_q;

    // ceil(2^SH/k^2): error per unit stays below 2^-SH * k^2, exact for every reachable sum
    for (genvar g = 0; g < 2**KW; g++) begin : g_rcp
        localparam longint D = (g == 0) ? 1 : g * g;
        assign rcp_tab[g] = RW'(((64'd1 << SH) + 64'(D) - 64'd1) / 64'(D));
    end

    always_comb begin
        sm0 = '0;
        for (int ch = 0; ch < CH_NUM; ch++)
            for (int i = 0; i < WIN_MAX; i++)
                for (int j = 0; j < WIN_MAX; j++)
                    if (KW'(i) < k_c && KW'(j) < k_c) sm0[ch] = sm0[ch] + AW'(win_d[i][j][ch]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q <= 1'b0;
            sm1_q <= '0;
            rcp1_q <= '0;
            avg1_q <= 1'b0;
        end else begin
            if (start) mode_q <= bus.mode;
            if (emit) begin
                sm1_q <= sm0;
                rcp1_q <= rcp_tab[k_c];
                avg1_q <= start ? bus.mode : mode_q;
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < CH_NUM; ch++)
            res[ch] = avg1_q ? DATA_WIDTH'(((AW+RW)'(sm1_q[ch]) * (AW+RW)'(rcp1_q)) >> SH) : mx1_q[ch];
    end
`else
    assign res = mx1_q;
`endif

    assign bus.fout_start = fout_q;
    assign bus.dout_vld = vld_q;
    assign bus.dout = dout_q;
    assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_pool_stream.sv
// tb_pool_stream: scoreboard bench for pool_stream; expectations come from a direct window model
module tb_pool_stream;
    localparam int DW = 8;
    localparam int CH = 16;
`ifdef POOL_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif
    typedef logic [CH*DW-1:0] pix_t;
    typedef struct {
        pix_t val;
        int   cyc;
        bit   first;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    exp_t q[$];
    pix_t last_dout;
    pix_t img [8][8];

    pool_stream_if bus ();
    pool_stream dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every dout_vld
    initial begin
        last_dout = '0;
        forever begin
            exp_t e;
            @(negedge clk);
            if (rst) last_dout = '0;
            else begin
                if (bus.dout_vld === 1'b1) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL extra_output cyc=%0d got dout=%h required no output", cyc, bus.dout);
                    end else begin
                        e = q.pop_front();
                        total += 3;
                        if (bus.dout !== e.val) begin
                            bad++;
                            $display("FAIL dout cyc=%0d got=%h required=%h", cyc, bus.dout, e.val);
                        end
                        if (cyc !== e.cyc) begin
                            bad++;
                            $display("FAIL latency got cyc=%0d required cyc=%0d", cyc, e.cyc);
                        end
                        if (bus.fout_start !== e.first) begin
                            bad++;
                            $display("FAIL fout_start cyc=%0d got=%b required=%b", cyc, bus.fout_start, e.first);
                        end
                    end
                end else begin
                    total += 2;
                    if (bus.fout_start !== 1'b0) begin
                        bad++;
                        $display("FAIL fout_without_vld cyc=%0d got=%b required=0", cyc, bus.fout_start);
                    end
                    if (bus.dout !== last_dout) begin
                        bad++;
                        $display("FAIL dout_hold cyc=%0d got=%h required=%h", cyc, bus.dout, last_dout);
                    end
                end
                last_dout = bus.dout;
            end
        end
    end

    // pat 0: ch0 raster, other channels random; pat 1: all 255 with ch1 = 1; pat 2: random
    task automatic drive_frame(input int h, input int w, input int k, input int s, input bit md,
                               input int pat, input bit gap, input int npix);
        bit legal = k >= 1 && k <= 3 && s >= 1 && s <= 4 && h >= k && h <= 224 && w >= k && w <= 224;
        bit first = 1'b1;
        int n = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                pix_t p;
                exp_t e;
                int mx, sm, v;
                if (n == npix) return;
                @(posedge clk); #1;
                for (int ch = 0; ch < CH; ch++)
                    p[ch*DW +: DW] = pat == 0 ? (ch == 0 ? DW'(r * w + c) : DW'($urandom)) :
                                     pat == 1 ? (ch == 1 ? 8'd1 : 8'd255) : DW'($urandom);
                if (r < 8 && c < 8) img[r][c] = p;
                bus.din_vld = 1'b1;
                bus.fin_start = n == 0;
                bus.din = p;
                bus.frame_h = n == 0 ? 9'(h) : 9'($urandom);
                bus.frame_w = n == 0 ? 9'(w) : 9'($urandom);
                bus.win_size = n == 0 ? 3'(k) : 3'($urandom);
                bus.stride = n == 0 ? 3'(s) : 3'($urandom);
                bus.mode = n == 0 ? md : 1'($urandom);
                if (legal && r >= k - 1 && c >= k - 1 && (r - k + 1) % s == 0 && (c - k + 1) % s == 0) begin
                    e.cyc = cyc + 2;
                    e.first = first;
                    first = 1'b0;
                    for (int ch = 0; ch < CH; ch++) begin
                        mx = 0;
                        sm = 0;
                        for (int dr = 0; dr < k; dr++)
                            for (int dc = 0; dc < k; dc++) begin
                                v = int'(img[r-dr][c-dc][ch*DW +: DW]);
                                if (v > mx) mx = v;
                                sm += v;
                            end
                        e.val[ch*DW +: DW] = (md && AVG_EN) ? DW'(sm / (k * k)) : DW'(mx);
                    end
                    q.push_back(e);
                end
                n++;
                if (gap) begin
                    @(posedge clk); #1;
                    bus.din_vld = 1'b0;
                    bus.fin_start = 1'b0;
                end
            end
    endtask

    task automatic drain(input string name);
        @(posedge clk); #1;
        bus.din_vld = 1'b0;
        bus.fin_start = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain pending=%0d required=0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        bus.din_vld = 1'b0;
        bus.fin_start = 1'b0;
        bus.din = '0;
        bus.frame_h = '0;
        bus.frame_w = '0;
        bus.win_size = '0;
        bus.stride = '0;
        bus.mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total += 4;
        if (bus.dout_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b required=0", bus.dout_vld); end
        if (bus.fout_start !== 1'b0) begin bad++; $display("FAIL reset_fout got=%b required=0", bus.fout_start); end
        if (bus.dout !== '0) begin bad++; $display("FAIL reset_dout got=%h required=0", bus.dout); end
        if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b required=0", bus.cfg_err); end
        rst = 1'b0;
    endtask

    task automatic test_max();
        drive_frame(4, 4, 2, 2, 1'b0, 0, 1'b0, -1);
        drain("max");
    endtask

    task automatic test_avg();
        drive_frame(5, 5, 3, 1, 1'b1, 1, 1'b0, -1);
        drain("avg");
    endtask

    task automatic test_gap();
        drive_frame(4, 4, 2, 2, 1'b0, 0, 1'b1, -1);
        drain("gap");
    endtask

    task automatic test_cfg_err();
        drive_frame(3, 3, 4, 1, 1'b0, 2, 1'b0, -1);
        drain("bad_k");
        total++;
        if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_k got=%b required=1", bus.cfg_err); end
        drive_frame(4, 4, 2, 2, 1'b0, 0, 1'b0, -1);
        drain("after_err");
        total++;
        if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_clear got=%b required=0", bus.cfg_err); end
        drive_frame(4, 4, 2, 5, 1'b0, 2, 1'b0, -1);
        drain("bad_s");
        total++;
        if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_s got=%b required=1", bus.cfg_err); end
    endtask

    task automatic test_abort();
        drive_frame(4, 4, 2, 2, 1'b0, 0, 1'b0, 9);
        drive_frame(4, 4, 2, 2, 1'b0, 2, 1'b0, -1);
        drain("abort");
    endtask

    task automatic test_back_to_back();
        drive_frame(7, 6, 3, 2, 1'b1, 2, 1'b0, -1);
        drive_frame(5, 7, 1, 3, 1'b0, 2, 1'b0, -1);
        drive_frame(1, 1, 1, 1, 1'b0, 2, 1'b0, -1);
        drive_frame(6, 6, 3, 4, 1'b1, 2, 1'b0, -1);
        drive_frame(8, 8, 3, 3, 1'b1, 2, 1'b1, -1);
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive_frame(4, 4, 2, 2, 1'b0, 0, 1'b0, 8);
        @(posedge clk); #1;
        bus.din_vld = 1'b0;
        bus.fin_start = 1'b0;
        @(posedge clk); #1;
        e = q.pop_front();
        total += 2;
        if (bus.dout_vld !== 1'b1) begin bad++; $display("FAIL mid_vld_before got=%b required=1", bus.dout_vld); end
        if (bus.dout !== e.val) begin bad++; $display("FAIL mid_dout_before got=%h required=%h", bus.dout, e.val); end
        rst = 1'b1;
        #1;
        total += 3;
        if (bus.dout_vld !== 1'b0) begin bad++; $display("FAIL mid_rst_vld got=%b required=0", bus.dout_vld); end
        if (bus.fout_start !== 1'b0) begin bad++; $display("FAIL mid_rst_fout got=%b required=0", bus.fout_start); end
        if (bus.dout !== '0) begin bad++; $display("FAIL mid_rst_dout got=%h required=0", bus.dout); end
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_frame(4, 4, 2, 2, 1'b0, 2, 1'b0, -1);
        drain("after_rst");
    endtask

    initial begin
        test_reset();
        test_max();
        test_avg();
        test_gap();
        test_cfg_err();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
